// File: rtl/memory_access_unit.sv
// memory_access_unit
// Load/store and stack engine in front of a single-port 16-bit data memory.
// LDD/STD/PUSH/POP take one cycle; CALL and RET take two cycles. They move a
// 32-bit return address as two 16-bit halves, with the high half at the
// higher address. Memory strobes and stall are combinational. Every other
// output is registered.
module memory_access_unit #(
    parameter logic [31:0] SP_INIT  = 32'h0000_07FF,
    parameter logic [31:0] SP_LIMIT = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] eaddr,
    input  logic [15:0] wdata,
    input  logic [31:0] pc_ret,
    input  logic [15:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_cs,
    output logic        stall,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        pc_valid,
    output logic [31:0] pc_out,
    output logic [31:0] sp,
    output logic        ovf,
    output logic        unf
);

    localparam logic [2:0] OP_LDD  = 3'd1;
    localparam logic [2:0] OP_STD  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALL_LO = 2'd1,
        ST_RET_HI  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] sp_r;
    logic [15:0] call_lo_r;   // low half of pc_ret, written in CALL_LO
    logic [15:0] ret_lo_r;    // low half read in the first RET cycle
    logic        rd_valid_r;
    logic [15:0] rd_data_r;
    logic        pc_valid_r;
    logic [31:0] pc_out_r;
    logic        ovf_r;
    logic        unf_r;

    logic [31:0] mem_addr_s;
    logic [15:0] mem_wdata_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        stall_s;

    // PUSH refuses once sp has reached the limit word.
    function automatic logic push_ok_f(input logic [31:0] s);
        return (s > SP_LIMIT);
    endfunction

    // POP needs at least one occupied word above sp.
    function automatic logic pop_ok_f(input logic [31:0] s);
        return (s < SP_INIT);
    endfunction

    // CALL needs two free words. After it, sp must not drop below the limit,
    // which matches PUSH stopping at sp == SP_LIMIT.
    // The comparison is done in 33 bits so that sp - 1 cannot wrap.
    function automatic logic call_ok_f(input logic [31:0] s);
        return ({1'b0, s} > ({1'b0, SP_LIMIT} + 33'd1));
    endfunction

    // RET needs two occupied words. The comparison is done in 33 bits so
    // that sp + 2 cannot wrap.
    function automatic logic ret_ok_f(input logic [31:0] s);
        return (({1'b0, s} + 33'd2) <= {1'b0, SP_INIT});
    endfunction

    // Memory strobes and stall, decoded from the current state and the op.
    // All of them are forced low during reset.
    always_comb begin
        mem_addr_s  = 32'd0;
        mem_wdata_s = 16'd0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        stall_s     = 1'b0;
        if (!rst_n) begin
            mem_read_s  = 1'b0;
            mem_write_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_LDD: begin
                                mem_addr_s = eaddr;
                                mem_read_s = 1'b1;
                            end
                            OP_STD: begin
                                mem_addr_s  = eaddr;
                                mem_wdata_s = wdata;
                                mem_write_s = 1'b1;
                            end
                            OP_PUSH: begin
                                if (push_ok_f(sp_r)) begin
                                    mem_addr_s  = sp_r;
                                    mem_wdata_s = wdata;
                                    mem_write_s = 1'b1;
                                end else begin
                                    mem_write_s = 1'b0;
                                end
                            end
                            OP_POP: begin
                                if (pop_ok_f(sp_r)) begin
                                    mem_addr_s = sp_r + 32'd1;
                                    mem_read_s = 1'b1;
                                end else begin
                                    mem_read_s = 1'b0;
                                end
                            end
                            OP_CALL: begin
                                if (call_ok_f(sp_r)) begin
                                    mem_addr_s  = sp_r;
                                    mem_wdata_s = pc_ret[31:16];
                                    mem_write_s = 1'b1;
                                    stall_s     = 1'b1;
                                end else begin
                                    stall_s = 1'b0;
                                end
                            end
                            OP_RET: begin
                                if (ret_ok_f(sp_r)) begin
                                    mem_addr_s = sp_r + 32'd1;
                                    mem_read_s = 1'b1;
                                    stall_s    = 1'b1;
                                end else begin
                                    stall_s = 1'b0;
                                end
                            end
                            default: begin
                                mem_read_s  = 1'b0;
                                mem_write_s = 1'b0;
                            end
                        endcase
                    end else begin
                        mem_read_s  = 1'b0;
                        mem_write_s = 1'b0;
                    end
                end
                ST_CALL_LO: begin
                    mem_addr_s  = sp_r - 32'd1;
                    mem_wdata_s = call_lo_r;
                    mem_write_s = 1'b1;
                end
                ST_RET_HI: begin
                    mem_addr_s = sp_r + 32'd2;
                    mem_read_s = 1'b1;
                end
                default: begin
                    mem_read_s  = 1'b0;
                    mem_write_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer FSM, stack pointer and all registered outputs. The status
    // pulses default low each cycle. A reset mid-CALL/RET abandons the
    // second half.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sp_r       <= SP_INIT;
            call_lo_r  <= 16'd0;
            ret_lo_r   <= 16'd0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 16'd0;
            pc_valid_r <= 1'b0;
            pc_out_r   <= 32'd0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            pc_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_LDD: begin
                                rd_valid_r <= 1'b1;
                                rd_data_r  <= mem_rdata;
                            end
                            OP_PUSH: begin
                                if (push_ok_f(sp_r)) begin
                                    sp_r <= sp_r - 32'd1;
                                end else begin
                                    ovf_r <= 1'b1;
                                end
                            end
                            OP_POP: begin
                                if (pop_ok_f(sp_r)) begin
                                    sp_r       <= sp_r + 32'd1;
                                    rd_valid_r <= 1'b1;
                                    rd_data_r  <= mem_rdata;
                                end else begin
                                    unf_r <= 1'b1;
                                end
                            end
                            OP_CALL: begin
                                if (call_ok_f(sp_r)) begin
                                    call_lo_r <= pc_ret[15:0];
                                    state_r   <= ST_CALL_LO;
                                end else begin
                                    ovf_r <= 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (ret_ok_f(sp_r)) begin
                                    ret_lo_r <= mem_rdata;
                                    state_r  <= ST_RET_HI;
                                end else begin
                                    unf_r <= 1'b1;
                                end
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALL_LO: begin
                    sp_r    <= sp_r - 32'd2;
                    state_r <= ST_IDLE;
                end
                ST_RET_HI: begin
                    sp_r       <= sp_r + 32'd2;
                    pc_out_r   <= {mem_rdata, ret_lo_r};
                    pc_valid_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign mem_read  = mem_read_s;
    assign mem_write = mem_write_s;
    assign mem_cs    = mem_read_s | mem_write_s;
    assign stall     = stall_s;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign pc_valid  = pc_valid_r;
    assign pc_out    = pc_out_r;
    assign sp        = sp_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit
// Scoreboard bench for memory_access_unit. A reference stack model produces
// the expected writes, read addresses, read data and return PCs. These are
// queued when an op is driven and popped when the DUT shows them.
module tb_memory_access_unit;

    localparam logic [31:0] SP_INIT  = 32'h0000_07FF;
    localparam logic [31:0] SP_LIMIT = 32'h0000_0400;
    localparam logic [63:0] NONE     = 64'hFFFF_DEAD_DEAD_DEAD;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] eaddr;
    logic [15:0] wdata;
    logic [31:0] pc_ret;
    logic [15:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_cs;
    logic        stall;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        pc_valid;
    logic [31:0] pc_out;
    logic [31:0] sp;
    logic        ovf;
    logic        unf;

    memory_access_unit #(.SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .eaddr(eaddr),
        .wdata(wdata), .pc_ret(pc_ret), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_cs(mem_cs), .stall(stall),
        .rd_valid(rd_valid), .rd_data(rd_data), .pc_valid(pc_valid),
        .pc_out(pc_out), .sp(sp), .ovf(ovf), .unf(unf)
    );

    // Memory seen by the DUT, and the bench's independent reference copy.
    logic [15:0] mem     [0:2047];
    logic [15:0] ref_mem [0:2047];

    logic [47:0] wq[$];    // expected {addr, data} writes
    logic [31:0] rq[$];    // expected read addresses
    logic [15:0] rdq[$];   // expected rd_data
    logic [31:0] pcq[$];   // expected pc_out

    int n_cmp = 0;
    int n_err = 0;
    int ovf_cnt = 0, unf_cnt = 0, stall_cnt = 0, cs_cnt = 0;
    int exp_ovf = 0, exp_unf = 0;
    logic [31:0] m_sp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    assign mem_rdata = mem[mem_addr[10:0]];

    // Data memory write port
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[10:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Monitor: compares memory traffic and result strobes with the scoreboard,
    // and counts pulse cycles.
    always @(negedge clk) begin
        logic [63:0] e;
        chk("rw_excl", 64'(mem_read & mem_write), 64'd0);
        chk("cs_or", 64'(mem_cs), 64'(mem_read | mem_write));
        if (mem_write) begin
            e = (wq.size() != 0) ? 64'(wq.pop_front()) : NONE;
            chk("write", 64'({mem_addr, mem_wdata}), e);
        end
        if (mem_read) begin
            e = (rq.size() != 0) ? 64'(rq.pop_front()) : NONE;
            chk("read_addr", 64'(mem_addr), e);
        end
        if (rd_valid === 1'b1) begin
            e = (rdq.size() != 0) ? 64'(rdq.pop_front()) : NONE;
            chk("rd_data", 64'(rd_data), e);
        end
        if (pc_valid === 1'b1) begin
            e = (pcq.size() != 0) ? 64'(pcq.pop_front()) : NONE;
            chk("pc_out", 64'(pc_out), e);
        end
        if (ovf === 1'b1) ovf_cnt++;
        if (unf === 1'b1) unf_cnt++;
        if (stall === 1'b1) stall_cnt++;
        if (mem_cs === 1'b1) cs_cnt++;
    end

    // Drive one op, queue its expected effects and check the aftermath.
    // Called and returning at posedge+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] ea,
                         input logic [15:0] wd, input logic [31:0] pc);
        int s0;
        int exp_stall;
        s0 = stall_cnt;
        exp_stall = 0;
        case (o)
            3'd1: begin
                rq.push_back(ea);
                rdq.push_back(ref_mem[ea[10:0]]);
            end
            3'd2: begin
                wq.push_back({ea, wd});
                ref_mem[ea[10:0]] = wd;
            end
            3'd3: begin
                if (m_sp > SP_LIMIT) begin
                    wq.push_back({m_sp, wd});
                    ref_mem[m_sp[10:0]] = wd;
                    m_sp = m_sp - 32'd1;
                end else exp_ovf++;
            end
            3'd4: begin
                if (m_sp < SP_INIT) begin
                    rq.push_back(m_sp + 32'd1);
                    rdq.push_back(ref_mem[m_sp[10:0] + 11'd1]);
                    m_sp = m_sp + 32'd1;
                end else exp_unf++;
            end
            3'd5: begin
                if (m_sp - 32'd2 >= SP_LIMIT) begin
                    wq.push_back({m_sp, pc[31:16]});
                    wq.push_back({m_sp - 32'd1, pc[15:0]});
                    ref_mem[m_sp[10:0]] = pc[31:16];
                    ref_mem[m_sp[10:0] - 11'd1] = pc[15:0];
                    m_sp = m_sp - 32'd2;
                    exp_stall = 1;
                end else exp_ovf++;
            end
            3'd6: begin
                if (m_sp + 32'd2 <= SP_INIT) begin
                    rq.push_back(m_sp + 32'd1);
                    rq.push_back(m_sp + 32'd2);
                    pcq.push_back({ref_mem[m_sp[10:0] + 11'd2], ref_mem[m_sp[10:0] + 11'd1]});
                    m_sp = m_sp + 32'd2;
                    exp_stall = 1;
                end else exp_unf++;
            end
            default: ;
        endcase
        op_valid = 1'b1; op = o; eaddr = ea; wdata = wd; pc_ret = pc;
        @(posedge clk); #1;
        if (exp_stall == 1) begin
            @(posedge clk); #1;
        end
        op_valid = 1'b0; op = 3'd0;
        @(posedge clk); #1;
        chk("stall_cycles", 64'(stall_cnt - s0), 64'(exp_stall));
        chk("ovf_count", 64'(ovf_cnt), 64'(exp_ovf));
        chk("unf_count", 64'(unf_cnt), 64'(exp_unf));
        chk("sp", 64'(sp), 64'(m_sp));
    endtask

    initial begin
        int c0;
        int u0;
        int o0;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'd0;
            ref_mem[i] = 16'd0;
        end
        m_sp = SP_INIT;
        rst_n = 1'b0;
        // A store is driven during reset and must not reach memory.
        op_valid = 1'b1; op = 3'd2; eaddr = 32'd5; wdata = 16'h7777; pc_ret = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 64'(mem_cs), 64'd0);
        chk("rst_sp", 64'(sp), 64'h7FF);
        chk("rst_flags", 64'({rd_valid, pc_valid, ovf, unf}), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_pc_out", 64'(pc_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; op_valid = 1'b0; op = 3'd0;
        @(posedge clk); #1;

        // Push then pop from reset
        issue(3'd3, 32'd0, 16'hABCD, 32'd0);
        chk("push_sp", 64'(sp), 64'h7FE);
        issue(3'd4, 32'd0, 16'd0, 32'd0);
        chk("pop_data", 64'(rd_data), 64'hABCD);
        chk("pop_sp", 64'(sp), 64'h7FF);

        // Call and return
        issue(3'd5, 32'd0, 16'd0, 32'h1234_5678);
        chk("call_hi", 64'(mem[11'h7FF]), 64'h1234);
        chk("call_lo", 64'(mem[11'h7FE]), 64'h5678);
        issue(3'd6, 32'd0, 16'd0, 32'd0);
        chk("ret_pc", 64'(pc_out), 64'h1234_5678);
        chk("ret_sp", 64'(sp), 64'h7FF);

        // Underflow: POP and RET on an empty stack
        c0 = cs_cnt; u0 = unf_cnt;
        issue(3'd4, 32'd0, 16'd0, 32'd0);
        issue(3'd6, 32'd0, 16'd0, 32'd0);
        chk("uf_no_cs", 64'(cs_cnt - c0), 64'd0);
        chk("uf_pulses", 64'(unf_cnt - u0), 64'd2);
        chk("uf_sp", 64'(sp), 64'h7FF);

        // Load and store, NOP encodings, and op_valid low
        issue(3'd2, 32'd5, 16'h00FF, 32'd0);
        issue(3'd1, 32'd5, 16'd0, 32'd0);
        chk("ldd_data", 64'(rd_data), 64'h00FF);
        chk("ldd_sp", 64'(sp), 64'h7FF);
        c0 = cs_cnt;
        issue(3'd7, 32'd9, 16'h1111, 32'd0);
        issue(3'd0, 32'd9, 16'h1111, 32'd0);
        op = 3'd3; wdata = 16'h2222;
        @(posedge clk); #1;
        op = 3'd0;
        @(posedge clk); #1;
        chk("nop_no_cs", 64'(cs_cnt - c0), 64'd0);
        chk("nop_sp", 64'(sp), 64'h7FF);

        // Reset while in CALL_LO abandons the second write
        wq.push_back({m_sp, 16'hBEEF});
        ref_mem[m_sp[10:0]] = 16'hBEEF;
        op_valid = 1'b1; op = 3'd5; pc_ret = 32'hBEEF_F00D;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_cs", 64'(mem_cs), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; op_valid = 1'b0; op = 3'd0;
        @(negedge clk);
        chk("abort_sp", 64'(sp), 64'h7FF);
        chk("abort_strobes", 64'({mem_cs, stall, rd_valid, pc_valid, ovf, unf}), 64'd0);
        @(posedge clk); #1;
        m_sp = SP_INIT;
        issue(3'd3, 32'd0, 16'h5A5A, 32'd0);
        issue(3'd4, 32'd0, 16'd0, 32'd0);
        chk("abort_idle_pop", 64'(rd_data), 64'h5A5A);

        // Overflow: fill down to 0x402, a CALL reaches 0x400, then refusals
        while (m_sp > 32'h402) issue(3'd3, 32'd0, m_sp[15:0], 32'd0);
        chk("fill_sp", 64'(sp), 64'h402);
        issue(3'd5, 32'd0, 16'd0, 32'hCAFE_BABE);
        chk("full_sp", 64'(sp), 64'h400);
        c0 = cs_cnt; o0 = ovf_cnt;
        issue(3'd3, 32'd0, 16'h1111, 32'd0);
        issue(3'd5, 32'd0, 16'd0, 32'h0BAD_0BAD);
        chk("of_no_cs", 64'(cs_cnt - c0), 64'd0);
        chk("of_pulses", 64'(ovf_cnt - o0), 64'd2);
        chk("of_sp", 64'(sp), 64'h400);
        issue(3'd6, 32'd0, 16'd0, 32'd0);
        chk("of_ret_pc", 64'(pc_out), 64'hCAFE_BABE);
        issue(3'd3, 32'd0, 16'h3333, 32'd0);
        o0 = ovf_cnt;
        issue(3'd5, 32'd0, 16'd0, 32'h0BAD_0BAD);
        chk("of401_pulse", 64'(ovf_cnt - o0), 64'd1);
        chk("of401_sp", 64'(sp), 64'h401);

        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        chk("rdq_empty", 64'(rdq.size()), 64'd0);
        chk("pcq_empty", 64'(pcq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
